// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//
// Parametrised single-clock synchronous FIFO with an occupancy count,
// programmable almost-full / almost-empty thresholds, a synchronous flush and
// single-cycle overflow / underflow error pulses.
//
// Parameters
//   DATA_WIDTH : word width in bits (>= 1)
//   DEPTH      : number of entries, power of two, >= 2
//   AFULL_TH   : almost_full asserts when count >= AFULL_TH
//   AEMPTY_TH  : almost_empty asserts when count <= AEMPTY_TH
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear of pointers, count and data_out
//   data_in      in   write data
//   wr_en        in   write request
//   rd_en        in   read request
//   data_out     out  registered read data (holds when no read is accepted)
//   empty        out  count == 0
//   full         out  count == DEPTH
//   almost_empty out  count <= AEMPTY_TH
//   almost_full  out  count >= AFULL_TH
//   count        out  current occupancy
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  rdOk;
    logic                  wrOk;

    // Status flags decode straight from the count register so they only
    // change right after a clock edge.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));
    assign almost_full  = (count_q >= CNT_W'(AFULL_TH));

    // A read at full frees the slot the write needs, so both go through.
    // At empty the read is rejected even if a write arrives: no bypass.
    assign rdOk = rd_en && !empty;
    assign wrOk = wr_en && (!full || rd_en);

    // Next-state logic. Flush wins over everything and suppresses the error
    // pulses; the array itself is left untouched since the pointers reset.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            dataOut_d = '0;
        end else begin
            if (wrOk) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (rdOk) begin
                rdPtr_d   = rdPtr_q + PTR_W'(1);
                dataOut_d = mem[rdPtr_q];
            end
            if (wrOk && !rdOk) begin
                count_d = count_q + CNT_W'(1);
            end else if (rdOk && !wrOk) begin
                count_d = count_q - CNT_W'(1);
            end
            overflow_d  = wr_en && !wrOk;
            underflow_d = rd_en && !rdOk;
        end
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dataOut_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array has no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (wrOk && !flush) begin
            mem[wrPtr_q] <= data_in;
        end
    end

    assign data_out  = dataOut_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
